// File: rtl/booth_pkg.sv
// Shared types and constants for the parameterised radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // {Q0, Q_-1} codes that select an accumulator update; other codes leave it unchanged
    localparam logic [1:0] BOOTH_SUB = 2'b10;
    localparam logic [1:0] BOOTH_ADD = 2'b01;

endpackage

// File: rtl/booth_step_cnt.sv
// Down-counter that paces the Booth steps; holds at zero once reached.
module booth_step_cnt #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier, signed or unsigned, one step per cycle
// with a valid/ready handshake on both sides.
module booth_mult_param
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y_o,
    output logic               busy_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t state, state_next;

    logic [WIDTH:0]       m;
    logic [WIDTH:0]       q;
    logic                 q_m1;
    logic [WIDTH+1:0]     acc;
    logic [2*WIDTH-1:0]   y;

    logic [WIDTH+1:0]     m_ext;
    logic [WIDTH+1:0]     acc_sum;
    logic [WIDTH+1:0]     acc_next;
    logic [WIDTH:0]       q_next;
    logic [2*WIDTH+2:0]   prod_next;

    logic accept;
    logic step;
    logic cnt_zero;

    assign accept = (state == IDLE) && in_valid;
    assign step   = (state == CALC);

    booth_step_cnt #(
        .CW (CW)
    ) u_step_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (CW'(WIDTH)),
        .dec      (step),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = CALC;
            CALC:    if (cnt_zero)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy_o    = (state == CALC) || (state == DONE);
        out_valid = (state == DONE);
    end

    // One Booth step: conditional add/subtract, then arithmetic shift of {acc,Q,Q_-1}
    always_comb begin
        m_ext = {m[WIDTH], m};
        case ({q[0], q_m1})
            BOOTH_SUB: acc_sum = acc - m_ext;
            BOOTH_ADD: acc_sum = acc + m_ext;
            default:   acc_sum = acc;
        endcase
        acc_next  = {acc_sum[WIDTH+1], acc_sum[WIDTH+1:1]};
        q_next    = {acc_sum[0], q[WIDTH:1]};
        prod_next = {acc_next, q_next};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m    <= '0;
            q    <= '0;
            q_m1 <= 1'b0;
            acc  <= '0;
            y    <= '0;
        end else if (accept) begin
            m    <= signed_i ? {a_i[WIDTH-1], a_i} : {1'b0, a_i};
            q    <= signed_i ? {b_i[WIDTH-1], b_i} : {1'b0, b_i};
            q_m1 <= 1'b0;
            acc  <= '0;
        end else if (step) begin
            acc  <= acc_next;
            q    <= q_next;
            q_m1 <= q[0];
            if (cnt_zero) begin
                y <= prod_next[2*WIDTH-1:0];
            end
        end
    end

    assign y_o = y;

endmodule

// File: doc/booth_mult_param.md
BOOTH_MULT_PARAM -- requirements
Module: booth_mult_param

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8, giving the operand width in bits; legal range 2 to 32.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have the port in_valid, input, 1 bit: the operand pair and mode are valid.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-006 The block SHALL have the port a_i, input, WIDTH bits: the multiplicand.
REQ-007 The block SHALL have the port b_i, input, WIDTH bits: the multiplier.
REQ-008 The block SHALL have the port signed_i, input, 1 bit: 1 means two's-complement operands, 0 means unsigned.
REQ-009 The block SHALL have the port out_valid, output, 1 bit: y_o holds a completed product.
REQ-010 The block SHALL have the port out_ready, input, 1 bit: the consumer takes y_o this cycle.
REQ-011 The block SHALL have the port y_o, output, 2*WIDTH bits: the product.
REQ-012 The block SHALL have the port busy_o, output, 1 bit: an operation is in progress (CALC or DONE).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in CALC and DONE, in_ready SHALL be 0.
REQ-015 On a rising edge in IDLE with in_valid=1, the block SHALL capture the operands and enter CALC, with:
- multiplicand M = a_i extended to WIDTH+1 bits, sign-extended if signed_i=1, zero-extended otherwise;
- Q = b_i extended the same way;
- Q_-1 = 0, accumulator = 0, step counter = WIDTH.
REQ-016 The accumulator SHALL be WIDTH+2 bits wide, so that adding or subtracting M never overflows, including M = -2^(WIDTH-1).
REQ-017 Each CALC cycle SHALL perform one radix-2 Booth step:
- {Q0,Q_-1}=10: acc -= M;
- {Q0,Q_-1}=01: acc += M;
- otherwise no change;
- then arithmetic right shift of {acc,Q,Q_-1} by one, all in the same cycle.
REQ-018 The step counter SHALL decrement once per CALC cycle, and the FSM SHALL leave CALC for DONE after the step in which the counter equals 0, i.e. after exactly WIDTH+1 steps.
REQ-019 In DONE, out_valid SHALL be 1 and y_o SHALL equal the low 2*WIDTH bits of {acc,Q}, held stable until the handshake.
REQ-020 In DONE, a rising edge with out_ready=1 SHALL return the FSM to IDLE, clearing out_valid on the following cycle.
REQ-021 Latency SHALL be fixed: out_valid rises WIDTH+1 clock edges after the accepting edge, independent of the operand values.
REQ-022 in_valid asserted in CALC or DONE SHALL be ignored, with no capture and no state change.
REQ-023 Back-to-back throughput SHALL be one product per WIDTH+3 cycles at minimum; a new operand pair is accepted no earlier than the cycle after the DONE handshake.
REQ-024 signed_i SHALL be sampled only at acceptance, and changes during CALC or DONE SHALL have no effect.
REQ-025 out_ready held at 0 SHALL keep the FSM in DONE indefinitely with y_o unchanged.

Reset
REQ-026 When rst=0 at a rising edge, the block SHALL enter IDLE and clear all of the following to 0: accumulator, Q, Q_-1, M, step counter, y_o, out_valid, busy_o.
REQ-027 Reset asserted in CALC or DONE SHALL abandon the operation without producing out_valid, and in_ready SHALL read 1 on the first cycle after rst returns to 1.
REQ-028 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-029 A shared package booth_pkg SHALL hold:
- the state enum type (IDLE, CALC, DONE);
- the Booth-step decode constants for the {Q0,Q_-1} codes.
REQ-030 The step counter SHALL be a separate sub-module, booth_step_cnt, parametrised by width $clog2(WIDTH+1), with load, decrement enable and zero flag.
REQ-031 The FSM and datapath SHALL reside in booth_mult_param.
REQ-032 Outputs SHALL be registered or decoded only from the state register, with no input-to-output combinational path except none.

Verification
REQ-033 A bench at WIDTH=4 SHALL cover these directed scenarios:
- signed, a=-8 (1000), b=-8 -> y_o=0x40 after exactly 5 edges;
- signed, a=-8, b=7 -> y_o=0xC8 (-56);
- unsigned, a=15, b=15 -> y_o=0xE1 (225);
- unsigned, a=0, b=9 -> y_o=0x00, with latency still 5 edges.
REQ-034 Backpressure: with out_ready=0 for 10 cycles in DONE, out_valid=1 and y_o SHALL be constant; then out_ready=1 for one cycle -> IDLE, in_ready=1.
REQ-035 Busy-ignore: in_valid pulsed with a=3, b=3 during CALC of 5*6 -> only 30 (0x1E) is produced, and one out_valid pulse results.
REQ-036 Reset mid-CALC: rst=0 on the 2nd CALC cycle -> out_valid never rises, all outputs 0, and in_ready=1 after release.
REQ-037 Random sweep at WIDTH=8 and WIDTH=16, 1000 pairs per mode, SHALL match a reference product computed in the bench.
